// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
// The counter width is a function because a package cannot see the top's WIDTH.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // CNT_W for a given WIDTH; a 1-bit build still needs a 1-bit counter.
    function automatic int cntWidth(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_addsub_fa_slice.sv
// Combinational 1-bit full adder.
// The top reuses this single slice on every RUN cycle.
module fa_slice (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_co
);

    assign o_s  = i_a ^ i_b ^ i_c;
    assign o_co = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one bit per clock, LSB first, through one full-adder slice.
// Subtraction is computed as A + ~B + ~borrow_in, so the final carry is inverted into a borrow.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int CNT_W = cntWidth(WIDTH);

    state_t           r_state;
    state_t           w_nextState;
    logic [WIDTH-1:0] r_aSh;
    logic [WIDTH-1:0] r_bSh;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] w_resNext;
    logic [CNT_W-1:0] r_cnt;
    logic             r_c;
    logic             r_mode;
    logic             r_cMsbIn;
    logic             w_s;
    logic             w_co;
    logic             w_accept;
    logic             w_lastBit;

    fa_slice u_fa (
        .i_a  (r_aSh[0]),
        .i_b  (r_bSh[0]),
        .i_c  (r_c),
        .o_s  (w_s),
        .o_co (w_co)
    );

    assign w_accept  = (r_state == IDLE) && in_valid;
    assign w_lastBit = (r_state == RUN) && (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_nextState = RUN;
            RUN:     if (w_lastBit) w_nextState = DONE;
            DONE:    if (out_ready) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Result and flags are shown only in DONE so that partial sums never leak out.
    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
        result    = (r_state == DONE) ? r_res : '0;
        cout      = (r_state == DONE) & (r_c ^ r_mode);
        ovf       = (r_state == DONE) & (r_cMsbIn ^ r_c);
        zero      = (r_state == DONE) & (r_res == '0);
    end

    always_comb begin
        w_resNext            = r_res >> 1;
        w_resNext[WIDTH-1]   = w_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aSh    <= '0;
            r_bSh    <= '0;
            r_res    <= '0;
            r_cnt    <= '0;
            r_c      <= 1'b0;
            r_mode   <= MODE_ADD;
            r_cMsbIn <= 1'b0;
        end else if (w_accept) begin
            r_aSh    <= a;
            r_bSh    <= b ^ {WIDTH{mode}};
            r_mode   <= mode;
            r_c      <= cin ^ mode;
            r_cnt    <= '0;
            r_cMsbIn <= 1'b0;
        end else if (r_state == RUN) begin
            r_res <= w_resNext;
            r_aSh <= r_aSh >> 1;
            r_bSh <= r_bSh >> 1;
            r_c   <= w_co;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_lastBit) r_cMsbIn <= r_c;
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: an 8-bit and a 1-bit instance checked against
// an arithmetic reference model (integer sums/differences and signed range checks).
module tb_serial_addsub;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       inValid8, inReady8, mode8, cin8, outValid8, outReady8, cout8, ovf8, zero8;
    logic [7:0] a8, b8, result8;
    logic       inValid1, inReady1, mode1, cin1, outValid1, outReady1, cout1, ovf1, zero1;
    logic [0:0] a1, b1, result1;
    int         nAsserts = 0;
    int         nFails   = 0;

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid8), .in_ready(inReady8), .mode(mode8),
        .a(a8), .b(b8), .cin(cin8), .out_valid(outValid8), .out_ready(outReady8),
        .result(result8), .cout(cout8), .ovf(ovf8), .zero(zero8)
    );

    serial_addsub #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid1), .in_ready(inReady1), .mode(mode1),
        .a(a1), .b(b1), .cin(cin1), .out_valid(outValid1), .out_ready(outReady1),
        .result(result1), .cout(cout1), .ovf(ovf1), .zero(zero1)
    );

    // Reference: exact integer arithmetic on the unsigned and signed readings of the operands.
    function automatic void model(input int w, input logic mode, input logic [7:0] a,
                                  input logic [7:0] b, input logic cin, output logic [7:0] res,
                                  output logic co, output logic ov, output logic z);
        longint m, ua, ub, sa, sb, full, exact, lim;
        m   = (longint'(1) << w) - 1;
        lim = longint'(1) << (w - 1);
        ua  = longint'(a) & m;
        ub  = longint'(b) & m;
        sa  = (ua >= lim) ? ua - (m + 1) : ua;
        sb  = (ub >= lim) ? ub - (m + 1) : ub;
        if (!mode) begin
            full  = ua + ub + longint'(cin);
            co    = (full > m);
            exact = sa + sb + longint'(cin);
        end else begin
            full  = ua - ub - longint'(cin);
            co    = (ua < ub + longint'(cin));
            exact = sa - sb - longint'(cin);
        end
        res = 8'(full & m);
        ov  = (exact >= lim) || (exact < -lim);
        z   = ((full & m) == 0);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents one operand set away from the clock edge and waits for the accept edge.
    task automatic applyStimulus(input bit useW1, input logic mode, input logic [7:0] a,
                                 input logic [7:0] b, input logic cin);
        @(negedge clk);
        if (useW1) begin
            inValid1 = 1'b1; mode1 = mode; a1 = a[0]; b1 = b[0]; cin1 = cin;
            checkOutput("in_ready_w1", inReady1, 1'b1);
        end else begin
            inValid8 = 1'b1; mode8 = mode; a8 = a; b8 = b; cin8 = cin;
            checkOutput("in_ready_w8", inReady8, 1'b1);
        end
        @(posedge clk);
        #1;
        inValid1 = 1'b0;
        inValid8 = 1'b0;
    endtask

    task automatic runOp(input bit useW1, input logic mode, input logic [7:0] a,
                         input logic [7:0] b, input logic cin, input bit scramble, input int hold);
        logic [7:0] eRes;
        logic       eCo, eOv, eZ;
        int         w;
        int         lat;
        w = useW1 ? 1 : 8;
        model(w, mode, a, b, cin, eRes, eCo, eOv, eZ);
        applyStimulus(useW1, mode, a, b, cin);
        lat = 0;
        while (!(useW1 ? outValid1 : outValid8) && lat < 20) begin
            if (scramble && !useW1) begin
                inValid8 = 1'($urandom);
                a8       = 8'($urandom);
                b8       = 8'($urandom);
                mode8    = 1'($urandom);
                cin8     = 1'($urandom);
            end
            @(posedge clk);
            #1;
            lat++;
        end
        inValid8 = 1'b0;
        checkOutput("latency", 64'(lat), 64'(w));
        for (int h = 0; h <= hold; h++) begin
            checkOutput("out_valid", useW1 ? outValid1 : outValid8, 1'b1);
            checkOutput("in_ready_busy", useW1 ? inReady1 : inReady8, 1'b0);
            checkOutput("result", useW1 ? {7'b0, result1} : result8, eRes);
            checkOutput("cout", useW1 ? cout1 : cout8, eCo);
            checkOutput("ovf", useW1 ? ovf1 : ovf8, eOv);
            checkOutput("zero", useW1 ? zero1 : zero8, eZ);
            if (h < hold) begin
                @(posedge clk);
                #1;
            end
        end
        if (useW1) outReady1 = 1'b1; else outReady8 = 1'b1;
        @(posedge clk);
        #1;
        outReady1 = 1'b0;
        outReady8 = 1'b0;
        checkOutput("in_ready_after", useW1 ? inReady1 : inReady8, 1'b1);
        checkOutput("out_valid_after", useW1 ? outValid1 : outValid8, 1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n = 1'b0;
        inValid8 = 0; mode8 = 0; a8 = 0; b8 = 0; cin8 = 0; outReady8 = 0;
        inValid1 = 0; mode1 = 0; a1 = 0; b1 = 0; cin1 = 0; outReady1 = 0;
        #12;
        checkOutput("rst_in_ready", inReady8, 1'b1);
        checkOutput("rst_out_valid", outValid8, 1'b0);
        checkOutput("rst_result", result8, 8'h00);
        checkOutput("rst_flags", {cout8, ovf8, zero8}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;

        runOp(0, 1'b0, 8'h3C, 8'h05, 1'b0, 0, 0);
        runOp(0, 1'b0, 8'h7F, 8'h01, 1'b0, 0, 0);
        runOp(0, 1'b0, 8'hFF, 8'h00, 1'b1, 0, 0);
        runOp(0, 1'b1, 8'h05, 8'h07, 1'b0, 0, 0);
        runOp(0, 1'b1, 8'h80, 8'h01, 1'b0, 0, 0);
        runOp(0, 1'b1, 8'h10, 8'h0F, 1'b1, 0, 0);

        runOp(0, 1'b1, 8'h80, 8'h7F, 1'b1, 0, 5);
        runOp(0, 1'b0, 8'hA5, 8'h5A, 1'b1, 1, 0);

        applyStimulus(0, 1'b0, 8'h12, 8'h34, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", outValid8, 1'b0);
        checkOutput("midrst_result", result8, 8'h00);
        checkOutput("midrst_in_ready", inReady8, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("midrst_no_pulse", outValid8, 1'b0);
        runOp(0, 1'b1, 8'h40, 8'hC0, 1'b0, 0, 0);

        for (int i = 0; i < 20; i++) begin
            runOp(0, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 0, $urandom_range(0, 2));
        end

        for (int k = 0; k < 16; k++) begin
            logic [3:0] v;
            v = 4'(k);
            runOp(1, v[3], {7'b0, v[2]}, {7'b0, v[1]}, v[0], 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
